// File: rtl/i2c_scl_engine_if.sv
// Command/response bundle between the I2C master FSM and the bus-timing engine.
// The master drives commands; the engine reports completion, errors and sampled SDA bits.
interface i2c_scl_engine_if #(
    parameter int FRAME_BITS = 9
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd;
    logic [FRAME_BITS-1:0] tx_data;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;
    logic                  busy;

    modport master (
        output cmd_valid, cmd, tx_data,
        input  cmd_ready, rx_data, done, err, err_code, busy
    );

    modport slave (
        input  cmd_valid, cmd, tx_data,
        output cmd_ready, rx_data, done, err, err_code, busy
    );
endinterface

// File: rtl/i2c_scl_engine.sv
// I2C bus-timing engine: owns the SCL/SDA open-drain enables and sequences
// START, RESTART, one data+ACK frame, and STOP with slave clock stretching.
module i2c_scl_engine #(
    parameter int HALF_PERIOD = 20,
    parameter int FRAME_BITS  = 9,
    parameter int STRETCH_MAX = 1000
) (
    input  logic            clk,
    input  logic            rst,
    i2c_scl_engine_if.slave bus,
    output logic            scl_oe,
    output logic            sda_oe,
    input  logic            scl_in,
    input  logic            sda_in
);
    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [HW-1:0] HALF_LAST    = HW'(HALF_PERIOD - 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_MAX - 1);
    localparam logic [BW-1:0] TOP_BIT      = BW'(FRAME_BITS - 1);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        CMD_START   = 2'b00,
        CMD_XFER    = 2'b01,
        CMD_STOP    = 2'b10,
        CMD_RESTART = 2'b11
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE, S_START_A, S_START_B, S_HELD, S_BIT_LO, S_BIT_HI,
        S_STOP_A, S_STOP_B, S_STOP_C, S_RS_A, S_RS_B
    } state_t;

    state_t                state;
    logic [HW-1:0]         half_cnt;
    logic [SW-1:0]         stretch_cnt;
    logic [BW-1:0]         bit_idx;
    logic [FRAME_BITS-1:0] tx_q;

    logic          accept;
    logic          stalled;
    logic          half_end;
    logic          timeout;
    logic [BW-1:0] next_idx;

    // Phases that release SCL wait for the line to actually rise before timing the half-period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        stalled  = 1'b0;
        accept   = bus.cmd_valid && bus.cmd_ready;
        next_idx = bit_idx - 1'b1;
        if (state inside {S_START_A, S_BIT_HI, S_STOP_B, S_STOP_C, S_RS_B}) begin
            stalled = !scl_in;
        end
        half_end = !stalled && (half_cnt == HALF_LAST);
        timeout  = stalled && (stretch_cnt == STRETCH_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only; all outputs are registers,
    // so the asynchronous reset releases both lines the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            half_cnt     <= '0;
            stretch_cnt  <= '0;
            bit_idx      <= '0;
            tx_q         <= '0;
            scl_oe       <= 1'b0;
            sda_oe       <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= 2'b00;
            bus.busy     <= 1'b0;
            bus.rx_data  <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            stretch_cnt <= stalled ? stretch_cnt + 1'b1 : '0;
            if (state == S_IDLE || state == S_HELD || half_end) begin
                half_cnt <= '0;
            end else if (!stalled) begin
                half_cnt <= half_cnt + 1'b1;
            end

            if (timeout) begin
                state         <= S_IDLE;
                stretch_cnt   <= '0;
                scl_oe        <= 1'b0;
                sda_oe        <= 1'b0;
                bus.busy      <= 1'b0;
                bus.cmd_ready <= 1'b1;
                bus.err       <= 1'b1;
                bus.err_code  <= ERR_TIMEOUT;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (bus.cmd == CMD_START) begin
                                state         <= S_START_A;
                                scl_oe        <= 1'b0;
                                sda_oe        <= 1'b1;
                                bus.cmd_ready <= 1'b0;
                            end else begin
                                bus.err      <= 1'b1;
                                bus.err_code <= ERR_ILLEGAL;
                            end
                        end
                    end
                    S_HELD: begin
                        if (accept) begin
                            case (bus.cmd)
                                CMD_XFER: begin
                                    state         <= S_BIT_LO;
                                    tx_q          <= bus.tx_data;
                                    bit_idx       <= TOP_BIT;
                                    scl_oe        <= 1'b1;
                                    sda_oe        <= ~bus.tx_data[FRAME_BITS-1];
                                    bus.cmd_ready <= 1'b0;
                                end
                                CMD_STOP: begin
                                    state         <= S_STOP_A;
                                    scl_oe        <= 1'b1;
                                    sda_oe        <= 1'b1;
                                    bus.cmd_ready <= 1'b0;
                                end
                                CMD_RESTART: begin
                                    state         <= S_RS_A;
                                    scl_oe        <= 1'b1;
                                    sda_oe        <= 1'b0;
                                    bus.cmd_ready <= 1'b0;
                                end
                                default: begin
                                    bus.err      <= 1'b1;
                                    bus.err_code <= ERR_ILLEGAL;
                                end
                            endcase
                        end
                    end
                    S_START_A: if (half_end) begin
                        state  <= S_START_B;
                        scl_oe <= 1'b1;
                    end
                    S_START_B: if (half_end) begin
                        state         <= S_HELD;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                    end
                    S_BIT_LO: if (half_end) begin
                        state  <= S_BIT_HI;
                        scl_oe <= 1'b0;
                    end
                    S_BIT_HI: if (half_end) begin
                        bus.rx_data[bit_idx] <= sda_in;
                        scl_oe               <= 1'b1;
                        if (bit_idx == '0) begin
                            state         <= S_HELD;
                            sda_oe        <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.cmd_ready <= 1'b1;
                        end else begin
                            state   <= S_BIT_LO;
                            bit_idx <= next_idx;
                            sda_oe  <= ~tx_q[next_idx];
                        end
                    end
                    S_STOP_A: if (half_end) begin
                        state  <= S_STOP_B;
                        scl_oe <= 1'b0;
                    end
                    S_STOP_B: if (half_end) begin
                        state  <= S_STOP_C;
                        sda_oe <= 1'b0;
                    end
                    S_STOP_C: if (half_end) begin
                        state         <= S_IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                    end
                    S_RS_A: if (half_end) begin
                        state  <= S_RS_B;
                        scl_oe <= 1'b0;
                    end
                    S_RS_B: if (half_end) begin
                        state  <= S_START_A;
                        sda_oe <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_scl_engine.sv
// Bench for i2c_scl_engine: a line-level segment model predicts every output each cycle,
// while directed scenarios pin the model with hand-computed latencies and values.
module tb_i2c_scl_engine;
    localparam int HALF = 20;
    localparam int FB   = 9;
    localparam int SMAX = 1000;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_XFER  = 2'b01;
    localparam logic [1:0] C_STOP  = 2'b10;
    localparam logic [1:0] C_RS    = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_oe, sda_oe, scl_in, sda_in;
    logic hold_scl = 1'b0;
    logic sda_pull = 1'b0;

    i2c_scl_engine_if #(.FRAME_BITS(FB)) bus ();

    i2c_scl_engine #(
        .HALF_PERIOD(HALF),
        .FRAME_BITS (FB),
        .STRETCH_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe),
        .scl_in(scl_in),
        .sda_in(sda_in)
    );

    // Wired-AND bus: the engine or the slave can pull either line low.
    assign scl_in = !(scl_oe || hold_scl);
    assign sda_in = !(sda_oe || sda_pull);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- model: each command is a list of half-period line segments ----------------
    typedef struct {
        logic scl;
        logic sda;
        bit   smp;
        int   k;
    } seg_t;

    seg_t           segs[$];
    int             m_cnt, m_str;
    logic [1:0]     m_cmd;
    logic           e_scl, e_sda, e_busy, e_done, e_err, e_ready;
    logic [1:0]     e_code;
    logic [FB-1:0]  e_rx;

    function automatic void push(input logic scl, input logic sda, input bit smp, input int k);
        seg_t s;
        s.scl = scl; s.sda = sda; s.smp = smp; s.k = k;
        segs.push_back(s);
    endfunction

    function automatic void build(input logic [1:0] c, input logic [FB-1:0] tx);
        case (c)
            C_START: begin push(1'b0, 1'b1, 0, 0); push(1'b1, 1'b1, 0, 0); end
            C_XFER: begin
                for (int k = FB - 1; k >= 0; k--) begin
                    push(1'b1, ~tx[k], 0, 0);
                    push(1'b0, ~tx[k], 1, k);
                end
            end
            C_STOP: begin push(1'b1, 1'b1, 0, 0); push(1'b0, 1'b1, 0, 0); push(1'b0, 1'b0, 0, 0); end
            default: begin
                push(1'b1, 1'b0, 0, 0); push(1'b0, 1'b0, 0, 0);
                push(1'b0, 1'b1, 0, 0); push(1'b1, 1'b1, 0, 0);
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            segs.delete();
            m_cnt = 0; m_str = 0; m_cmd = C_START;
            e_scl = 0; e_sda = 0; e_busy = 0; e_done = 0; e_err = 0; e_ready = 1;
            e_code = 2'b00; e_rx = '0;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (segs.size() == 0) begin
                if (bus.cmd_valid && e_ready) begin
                    if ((!e_busy && bus.cmd == C_START) || (e_busy && bus.cmd != C_START)) begin
                        build(bus.cmd, bus.tx_data);
                        m_cmd = bus.cmd; m_cnt = 0; m_str = 0; e_ready = 0;
                        e_scl = segs[0].scl; e_sda = segs[0].sda;
                    end else begin
                        e_err = 1; e_code = 2'b01;
                    end
                end
            end else if (!segs[0].scl && !scl_in) begin
                m_str++;
                if (m_str == SMAX) begin
                    segs.delete();
                    e_scl = 0; e_sda = 0; e_busy = 0; e_err = 1; e_code = 2'b10; e_ready = 1;
                end
            end else begin
                m_str = 0;
                m_cnt++;
                if (m_cnt == HALF) begin
                    if (segs[0].smp) e_rx[segs[0].k] = sda_in;
                    void'(segs.pop_front());
                    m_cnt = 0;
                    if (segs.size() > 0) begin
                        e_scl = segs[0].scl; e_sda = segs[0].sda;
                    end else begin
                        e_done = 1; e_ready = 1;
                        e_busy = (m_cmd != C_STOP);
                        e_scl  = (m_cmd != C_STOP);
                        e_sda  = (m_cmd == C_START || m_cmd == C_RS);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("scl_oe",    scl_oe,        e_scl);
            check("sda_oe",    sda_oe,        e_sda);
            check("busy",      bus.busy,      e_busy);
            check("done",      bus.done,      e_done);
            check("err",       bus.err,       e_err);
            check("err_code",  bus.err_code,  e_code);
            check("cmd_ready", bus.cmd_ready, e_ready);
            check("rx_data",   bus.rx_data,   e_rx);
        end
    end

    // ---------------- directed stimulus ----------------
    int t_acc;
    int lat;

    task automatic issue(input logic [1:0] c, input logic [FB-1:0] tx);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.tx_data   = tx;
        t_acc         = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int l);
        l = -1;
        for (int i = 0; i < max; i++) begin
            if (bus.done || bus.err) begin
                l = cyc - t_acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.tx_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_ready",  bus.cmd_ready, 1);
        check("rst_code",   bus.err_code, 0);
        check("rst_rx",     bus.rx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // START: SDA falls first, SCL half a period later, done at +41
        issue(C_START, '0);
        check("start_sda_t1", sda_oe, 1);
        check("start_scl_t1", scl_oe, 0);
        repeat (19) @(negedge clk);
        check("start_scl_t20", scl_oe, 0);
        @(negedge clk);
        check("start_scl_t21", scl_oe, 1);
        wait_done(100, lat);
        check("start_lat", lat, 41);
        check("start_busy", bus.busy, 1);

        // XFER 0x44 + released ACK slot; slave acks
        @(negedge clk);
        issue(C_XFER, 9'h089);
        check("xfer_sda_t1", sda_oe, 1);
        wait_until(t_acc + 330);
        sda_pull = 1'b1;
        wait_done(100, lat);
        sda_pull = 1'b0;
        check("xfer_lat", lat, 361);
        check("xfer_rx", bus.rx_data, 9'h088);
        check("xfer_held_scl", scl_oe, 1);
        check("xfer_held_sda", sda_oe, 0);

        // START while held is illegal
        @(negedge clk);
        issue(C_START, '0);
        check("ill_start_err", bus.err, 1);
        check("ill_start_code", bus.err_code, 2'b01);
        check("ill_start_scl", scl_oe, 1);

        // 50-cycle stretch in bit 3 high phase
        @(negedge clk);
        issue(C_XFER, 9'h1A5);
        wait_until(t_acc + 215);
        hold_scl = 1'b1;
        wait_until(t_acc + 271);
        hold_scl = 1'b0;
        wait_done(500, lat);
        check("stretch_lat", lat, 411);
        check("stretch_rx", bus.rx_data, 9'h1A5);

        // RESTART, then STOP accepted in the done cycle
        @(negedge clk);
        issue(C_RS, '0);
        wait_done(200, lat);
        check("rs_lat", lat, 81);
        check("rs_busy", bus.busy, 1);
        issue(C_STOP, '0);
        check("stop_t1_scl", scl_oe, 1);
        check("stop_t1_sda", sda_oe, 1);
        wait_until(t_acc + 40);
        check("stop_t40_scl", scl_oe, 0);
        check("stop_t40_sda", sda_oe, 1);
        @(negedge clk);
        check("stop_t41_sda", sda_oe, 0);
        wait_done(100, lat);
        check("stop_lat", lat, 61);
        check("stop_busy", bus.busy, 0);

        // XFER while idle is illegal
        @(negedge clk);
        issue(C_XFER, 9'h0FF);
        check("ill_xfer_err", bus.err, 1);
        check("ill_xfer_code", bus.err_code, 2'b01);
        check("ill_xfer_sda", sda_oe, 0);

        // SCL stuck low: timeout
        @(negedge clk);
        issue(C_START, '0);
        wait_done(100, lat);
        @(negedge clk);
        issue(C_XFER, 9'h1FF);
        hold_scl = 1'b1;
        wait_done(1200, lat);
        check("to_lat", lat, 1021);
        check("to_code", bus.err_code, 2'b10);
        check("to_done", bus.done, 0);
        check("to_scl", scl_oe, 0);
        check("to_sda", sda_oe, 0);
        check("to_busy", bus.busy, 0);
        hold_scl = 1'b0;

        // reset in the middle of a frame
        @(negedge clk);
        issue(C_START, '0);
        wait_done(100, lat);
        @(negedge clk);
        issue(C_XFER, 9'h000);
        wait_until(t_acc + 100);
        check("pre_rst_sda", sda_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_scl", scl_oe, 0);
        check("mid_rst_sda", sda_oe, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.cmd_ready, 1);
        check("mid_rst_code", bus.err_code, 0);
        check("mid_rst_rx", bus.rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(C_START, '0);
        wait_done(100, lat);
        check("post_rst_lat", lat, 41);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
